// File: rtl/devolvedor_moedas.sv
// devolvedor_moedas: coin-return driver that ejects refund or change as timed solenoid pulses
// Parameters:
//   PULSE_CYCLES - cycles ejetar stays high per coin (>=1)
//   GAP_CYCLES   - cycles ejetar stays low after each pulse (>=1)
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-high reset
//   devolver  - refund request level; rising edge starts a full refund of total
//   liberar   - product-release level; rising edge starts change return (total - valor)
//   total     - current credit in coin units
//   valor     - price of the selected product in coin units
//   ejetar    - registered solenoid drive, one pulse per coin
//   ocupado   - high while a return sequence is in progress
//   pendentes - coins still to eject
//   concluido - one-cycle pulse when a sequence ends
// Build option: define DEVOLVE_TROCO_EN to enable change return on liberar;
// without it only devolver triggers, liberar and valor are ignored.
module devolvedor_moedas #(
   parameter int PULSE_CYCLES = 2_500_000,
   parameter int GAP_CYCLES   = 5_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       devolver,
   input  logic       liberar,
   input  logic [3:0] total,
   input  logic [3:0] valor,
   output logic       ejetar,
   output logic       ocupado,
   output logic [3:0] pendentes,
   output logic       concluido
);
   localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   typedef enum logic [1:0] {OCIOSO, PULSO, PAUSA, FIM} state_t;
   state_t          state, state_n;
   logic [CW-1:0]   cnt;
   logic            ejetar_n, ocupado_n, concluido_n;
   logic [3:0]      pend_n, amt;
   logic            dev_q, dev_tr, trig, pulse_end, gap_end;
   assign dev_tr = devolver & ~dev_q;
`ifdef DEVOLVE_TROCO_EN
   logic       lib_q, lib_tr;
   logic [4:0] diff;
   assign lib_tr = liberar & ~lib_q;
   assign diff   = {1'b0, total} - {1'b0, valor};
   assign trig   = dev_tr | lib_tr;
   // refund wins on simultaneous edges; a borrow clamps change to zero
   assign amt    = dev_tr ? total : (diff[4] ? 4'd0 : diff[3:0]);
`else
   logic unused_ok;
   assign unused_ok = ^{liberar, valor};
   assign trig      = dev_tr;
   assign amt       = total;
`endif
   assign pulse_end = (state == PULSO) && (cnt == CW'(PULSE_CYCLES - 1));
   assign gap_end   = (state == PAUSA) && (cnt == CW'(GAP_CYCLES - 1));
   always_comb begin
      state_n     = state;
      ejetar_n    = ejetar;
      ocupado_n   = ocupado;
      concluido_n = 1'b0;
      pend_n      = pendentes;
      case (state)
         OCIOSO: begin
            ocupado_n = 1'b0;
            if (trig) begin
               state_n = (amt != 4'd0) ? PULSO : FIM;
               ejetar_n  = (amt != 4'd0);
               ocupado_n = (amt != 4'd0);
               pend_n    = amt;
            end
         end
         PULSO: if (pulse_end) begin
            state_n  = PAUSA;
            ejetar_n = 1'b0;
            pend_n   = pendentes - 4'd1;
         end
         PAUSA: if (gap_end) begin
            state_n     = (pendentes != 4'd0) ? PULSO : FIM;
            ejetar_n    = (pendentes != 4'd0);
            ocupado_n   = (pendentes != 4'd0);
            concluido_n = (pendentes == 4'd0);
         end
         default: begin
            // coin path arrives here with concluido already raised; the
            // zero-amount path raises it (with ocupado) on the way out
            state_n     = OCIOSO;
            concluido_n = ~concluido;
            ocupado_n   = ~concluido;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= OCIOSO;
         cnt       <= '0;
         ejetar    <= 1'b0;
         ocupado   <= 1'b0;
         concluido <= 1'b0;
         pendentes <= 4'd0;
         dev_q     <= 1'b1;
`ifdef DEVOLVE_TROCO_EN
         lib_q     <= 1'b1;
`endif
      end else begin
         state     <= state_n;
         cnt       <= (state_n != state) ? '0 : cnt + CW'(1);
         ejetar    <= ejetar_n;
         ocupado   <= ocupado_n;
         concluido <= concluido_n;
         pendentes <= pend_n;
         dev_q     <= devolver;
`ifdef DEVOLVE_TROCO_EN
         lib_q     <= liberar;
`endif
      end
   end
endmodule

// File: tb/tb_devolvedor_moedas.sv
// tb_devolvedor_moedas: scoreboard bench for devolvedor_moedas with PULSE_CYCLES=3, GAP_CYCLES=2
module tb_devolvedor_moedas;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       devolver = 1'b0;
   logic       liberar = 1'b0;
   logic [3:0] total = 4'd0;
   logic [3:0] valor = 4'd0;
   logic       ejetar, ocupado, concluido;
   logic [3:0] pendentes;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   typedef struct {int n; int amt;} exp_t;
   exp_t q[$];
   devolvedor_moedas #(.PULSE_CYCLES(3), .GAP_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .devolver(devolver), .liberar(liberar),
      .total(total), .valor(valor), .ejetar(ejetar), .ocupado(ocupado),
      .pendentes(pendentes), .concluido(concluido)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   // monitor: pulse shape, pendentes at each pulse start, and completion timing
   int  np = 0;
   int  run = 0;
   logic pe = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         np = 0;
         run = 0;
         pe = 1'b0;
      end else begin
         run++;
         if (ejetar != pe) begin
            if (!ejetar) chk("pulse_width", run - 1, 3);
            else begin
               if (np > 0) chk("gap_width", run - 1, 2);
               if (q.size() != 0) chk("pendentes_at_pulse", int'(pendentes), q[0].amt - np);
               else chk("pulse_without_request", 1, 0);
               np++;
            end
            run = 1;
         end
         if (concluido) begin
            if (q.size() == 0) chk("unexpected_concluido", 1, 0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("pulse_count", np, e.amt);
               chk("concluido_edge", cyc, e.n + ((e.amt != 0) ? e.amt * 5 : 1));
               chk("ocupado_at_concluido", int'(ocupado), (e.amt == 0) ? 1 : 0);
               chk("pendentes_at_end", int'(pendentes), 0);
            end
            np = 0;
         end
         pe = ejetar;
      end
   end
   task automatic wait_done(input string nm);
      for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
      chk({nm, "_completed"}, q.size(), 0);
      repeat (3) @(negedge clk);
   endtask
   task automatic start(input logic d, input logic l, input int t, input int v, input int k);
      @(negedge clk);
      total = 4'(t);
      valor = 4'(v);
      devolver = d;
      liberar = l;
      q.push_back('{cyc + 1, k});
      @(negedge clk);
      total = 4'd15;
      valor = 4'd0;
      devolver = 1'b0;
      liberar = 1'b0;
   endtask
   task automatic wait_pulse2(input string nm);
      int i;
      for (i = 0; i < 100 && !(ejetar && pendentes == 4'd2); i++) @(negedge clk);
      chk({nm, "_reached_pulse2"}, (ejetar && pendentes == 4'd2) ? 1 : 0, 1);
   endtask
   task automatic idle_check(input string nm, input int n);
      repeat (n) @(negedge clk);
      chk(nm, {ejetar, ocupado, concluido, pendentes}, 0);
   endtask
   initial begin
      @(negedge clk);
      chk("reset_outputs", {ejetar, ocupado, concluido, pendentes}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      while (cyc < 9) @(negedge clk);
      // refund of 3 with the trigger at edge 10, completion after edge 25
      total = 4'd3;
      devolver = 1'b1;
      q.push_back('{10, 3});
      @(negedge clk);
      chk("ocupado_after_trigger", int'(ocupado), 1);
      chk("pendentes_after_trigger", int'(pendentes), 3);
      total = 4'd9;
      devolver = 1'b0;
      wait_done("refund3");
`ifdef DEVOLVE_TROCO_EN
      start(1'b0, 1'b1, 7, 4, 3);
      wait_done("change_7_4");
      start(1'b0, 1'b1, 4, 4, 0);
      wait_done("change_4_4");
      start(1'b0, 1'b1, 2, 5, 0);
      wait_done("change_2_5");
      start(1'b0, 1'b1, 15, 1, 14);
      wait_done("change_15_1");
`else
      @(negedge clk);
      total = 4'd6;
      liberar = 1'b1;
      idle_check("liberar_ignored", 10);
      liberar = 1'b0;
      start(1'b1, 1'b0, 6, 0, 6);
      wait_done("refund6");
`endif
      start(1'b1, 1'b1, 5, 2, 5);
      wait_done("simultaneous");
      start(1'b1, 1'b0, 0, 0, 0);
      wait_done("refund0");
      // retrigger during the second pulse must be ignored
      start(1'b1, 1'b0, 3, 0, 3);
      wait_pulse2("busy");
      devolver = 1'b1;
      @(negedge clk);
      devolver = 1'b0;
      wait_done("busy");
      idle_check("no_second_sequence", 15);
      // reset mid-pulse with 2 coins pending, devolver held through release
      start(1'b1, 1'b0, 3, 0, 3);
      wait_pulse2("reset");
      reset = 1'b1;
      devolver = 1'b1;
      @(negedge clk);
      chk("outputs_after_reset", {ejetar, ocupado, concluido, pendentes}, 0);
      @(negedge clk);
      reset = 1'b0;
      idle_check("held_devolver_no_trigger", 15);
      devolver = 1'b0;
      start(1'b1, 1'b0, 2, 0, 2);
      wait_done("after_reset");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
